// File: rtl/pc_fetch_unit.sv
// PC fetch unit: holds the architectural PC, issues one IM read per PC and hands {Pc, instruction} downstream.
// Optional misaligned-PC redirect is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Npc,
  output logic [31:0] Pc,
  output logic [31:0] instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_cnt,
  output logic        exc_misalign
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc_next;
  logic        misaligned;

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    misaligned = (Npc[1:0] != 2'b00);
    pc_next    = misaligned ? EXC_VECTOR : Npc;
  end
`else
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;

  always_comb begin
    misaligned = 1'b0;
    pc_next    = Npc;
  end
`endif

  assign imem_addr = Pc;

  // imem_req and exc_misalign are registered so both are high exactly for the S_REQ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_BOOT;
      Pc           <= RESET_PC;
      instruction  <= 32'h0;
      inst_valid   <= 1'b0;
      imem_req     <= 1'b0;
      fetch_cnt    <= 32'h0;
      exc_misalign <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          imem_req <= 1'b1;
          state    <= S_REQ;
        end
        S_REQ: begin
          imem_req     <= 1'b0;
          exc_misalign <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instruction <= imem_rdata;
            inst_valid  <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            Pc           <= pc_next;
            fetch_cnt    <= fetch_cnt + 32'd1;
            inst_valid   <= 1'b0;
            imem_req     <= 1'b1;
            exc_misalign <= misaligned;
            state        <= S_REQ;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; expectations follow the PC_ALIGN_CHECK_EN setting.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] Npc;
  logic [31:0] Pc;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] fetch_cnt;
  logic        exc_misalign;

  int compared;
  int mismatched;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Npc          (Npc),
    .Pc           (Pc),
    .instruction  (instruction),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .fetch_cnt    (fetch_cnt),
    .exc_misalign (exc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] npc_v, input logic ready_v,
                               input logic rvalid_v, input logic [31:0] rdata_v);
    Npc         = npc_v;
    inst_ready  = ready_v;
    imem_rvalid = rvalid_v;
    imem_rdata  = rdata_v;
  endtask

  // Four-output snapshot of the fetch/handshake interface.
  task automatic checkFetch(input string tag, input logic [31:0] pc_e, input logic valid_e,
                            input logic req_e, input logic [31:0] cnt_e);
    checkOutput({tag, "_pc"}, Pc, pc_e);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, valid_e});
    checkOutput({tag, "_req"}, {31'b0, imem_req}, {31'b0, req_e});
    checkOutput({tag, "_cnt"}, fetch_cnt, cnt_e);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset values");
    checkFetch("rst", 32'h0000_3000, 1'b0, 1'b0, 32'd0);
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_exc", {31'b0, exc_misalign}, 32'h0);
    rst_n = 1'b1;

    $display("[TB] first fetch, IM latency 1");
    step();
    checkFetch("boot_req", 32'h0000_3000, 1'b0, 1'b1, 32'd0);
    checkOutput("boot_addr", imem_addr, 32'h0000_3000);
    step();
    checkFetch("boot_wait", 32'h0000_3000, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0000_3004, 1'b0, 1'b1, 32'h3C01_1234);
    step();
    applyStimulus(32'h0000_3004, 1'b0, 1'b0, 32'h0);
    checkFetch("first_hold", 32'h0000_3000, 1'b1, 1'b0, 32'd0);
    checkOutput("first_instr", instruction, 32'h3C01_1234);

    $display("[TB] stall five cycles");
    for (int i = 0; i < 5; i++) begin
      step();
      checkFetch("stall", 32'h0000_3000, 1'b1, 1'b0, 32'd0);
      checkOutput("stall_instr", instruction, 32'h3C01_1234);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checkFetch("acc1", 32'h0000_3004, 1'b0, 1'b1, 32'd1);
    checkOutput("acc1_addr", imem_addr, 32'h0000_3004);

    $display("[TB] IM latency 4 and spurious rvalid");
    for (int i = 0; i < 3; i++) begin
      step();
      checkFetch("lat4_wait", 32'h0000_3004, 1'b0, 1'b0, 32'd1);
      checkOutput("lat4_instr", instruction, 32'h3C01_1234);
    end
    applyStimulus(32'h0000_3004, 1'b0, 1'b1, 32'hAAAA_0001);
    step();
    checkFetch("lat4_hold", 32'h0000_3004, 1'b1, 1'b0, 32'd1);
    checkOutput("lat4_data", instruction, 32'hAAAA_0001);
    applyStimulus(32'h0000_9990, 1'b0, 1'b1, 32'hDEAD_BEEF);
    repeat (2) step();
    checkOutput("spurious_instr", instruction, 32'hAAAA_0001);
    checkFetch("spurious", 32'h0000_3004, 1'b1, 1'b0, 32'd1);

    $display("[TB] branch target and self-loop");
    applyStimulus(32'h0000_3010, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(32'h0000_3010, 1'b0, 1'b1, 32'hBAD0_BAD0);
    checkFetch("branch", 32'h0000_3010, 1'b0, 1'b1, 32'd2);
    step();
    checkOutput("req_rvalid_ignored", instruction, 32'hAAAA_0001);
    checkFetch("branch_wait", 32'h0000_3010, 1'b0, 1'b0, 32'd2);
    imem_rdata = 32'h3010_0001;
    step();
    applyStimulus(32'h0000_3010, 1'b1, 1'b0, 32'h0);
    checkOutput("branch_instr", instruction, 32'h3010_0001);
    step();
    inst_ready = 1'b0;
    checkFetch("selfloop", 32'h0000_3010, 1'b0, 1'b1, 32'd3);
    checkOutput("selfloop_addr", imem_addr, 32'h0000_3010);
    step();
    applyStimulus(32'h0000_3010, 1'b0, 1'b1, 32'h2222_0002);
    step();
    applyStimulus(32'h0000_3006, 1'b1, 1'b0, 32'h0);
    checkOutput("selfloop_instr", instruction, 32'h2222_0002);

    $display("[TB] misaligned Npc");
    step();
    inst_ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    checkFetch("misalign", 32'h0000_4180, 1'b0, 1'b1, 32'd4);
    checkOutput("misalign_exc", {31'b0, exc_misalign}, 32'd1);
`else
    checkFetch("misalign", 32'h0000_3006, 1'b0, 1'b1, 32'd4);
    checkOutput("misalign_exc", {31'b0, exc_misalign}, 32'd0);
`endif
    step();
    checkOutput("misalign_exc_drop", {31'b0, exc_misalign}, 32'd0);

    $display("[TB] reset during S_WAIT");
    #2;
    rst_n = 1'b0;
    #1;
    checkFetch("rst_wait", 32'h0000_3000, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0000_3004, 1'b0, 1'b1, 32'h5555_5555);
    step();
    checkOutput("rst_rvalid_ignored", instruction, 32'h0);
    rst_n = 1'b1;
    step();
    checkFetch("restart_req", 32'h0000_3000, 1'b0, 1'b1, 32'd0);
    checkOutput("restart_addr", imem_addr, 32'h0000_3000);
    checkOutput("restart_instr", instruction, 32'h0);
    step();
    imem_rdata = 32'h3C01_1234;
    step();
    imem_rvalid = 1'b0;
    checkFetch("restart_hold", 32'h0000_3000, 1'b1, 1'b0, 32'd0);
    checkOutput("restart_data", instruction, 32'h3C01_1234);

    $display("[TB] async reset during S_HOLD");
    #2;
    rst_n = 1'b0;
    #1;
    checkFetch("rst_hold", 32'h0000_3000, 1'b0, 1'b0, 32'd0);
    checkOutput("rst_hold_instr", instruction, 32'h0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
